speck_iterative_core: RTL and testbench

Iterative, parametrised SPECK block cipher core that performs encryption or decryption selected at run time, using one shared round datapath. It computes the key schedule once into an on-chip round-key buffer and keeps that buffer between operations. Decryption reads the buffer in reverse order, and back-to-back operations under an unchanged key skip re-expansion. It replaces the unrolled per-round key_schedule/round_decrypt chain as the production cipher engine for all SPECK block/key sizes with alpha = 8 and beta = 3.

---
 rtl/speck_iterative_core.sv | 180 ++++++++++++++++++
 tb/tb_speck_iterative_core.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/speck_iterative_core.sv
// Iterative SPECK encrypt/decrypt core (alpha = 8, beta = 3) with a cached round-key buffer.
// The key is expanded once into the buffer; decryption walks the buffer backwards.
module speck_iterative_core #(
    parameter int WORD_SIZE = 64,
    parameter int KEY_WORDS = 2,
    parameter int NR_ROUNDS = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           signal_start,
    input  logic                           mode,
    input  logic [KEY_WORDS*WORD_SIZE-1:0] key,
    input  logic                           key_invalidate,
    input  logic [2*WORD_SIZE-1:0]         data_in,
    output logic [2*WORD_SIZE-1:0]         data_out,
    output logic                           finished,
    output logic                           busy,
    output logic [1:0]                     state_response
);
    localparam int CTR_W = (NR_ROUNDS > 1) ? $clog2(NR_ROUNDS) : 1;
    localparam logic [CTR_W-1:0] LAST = CTR_W'(NR_ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                         state_q;
    logic [CTR_W-1:0]               ctr_q;
    logic                           key_valid_q;
    logic                           mode_q;
    logic [KEY_WORDS*WORD_SIZE-1:0] pend_key_q;
    logic [KEY_WORDS*WORD_SIZE-1:0] cached_key_q;
    logic [WORD_SIZE-1:0]           k_q;
    logic [WORD_SIZE-1:0]           l_q [KEY_WORDS-1];
    logic [WORD_SIZE-1:0]           x_q;
    logic [WORD_SIZE-1:0]           y_q;
    logic [2*WORD_SIZE-1:0]         data_out_q;
    logic                           finished_q;
    logic                           busy_q;
    logic [WORD_SIZE-1:0]           rk_mem [NR_ROUNDS];

    logic [WORD_SIZE-1:0] l_new_d;
    logic [WORD_SIZE-1:0] k_d;
    logic [WORD_SIZE-1:0] l_d [KEY_WORDS-1];
    logic [CTR_W-1:0]     rd_idx_d;
    logic [WORD_SIZE-1:0] rk_d;
    logic [WORD_SIZE-1:0] x_d;
    logic [WORD_SIZE-1:0] y_d;

    function automatic logic [WORD_SIZE-1:0] ror8(input logic [WORD_SIZE-1:0] v);
        return {v[7:0], v[WORD_SIZE-1:8]};
    endfunction

    function automatic logic [WORD_SIZE-1:0] rol8(input logic [WORD_SIZE-1:0] v);
        return {v[WORD_SIZE-9:0], v[WORD_SIZE-1:WORD_SIZE-8]};
    endfunction

    function automatic logic [WORD_SIZE-1:0] ror3(input logic [WORD_SIZE-1:0] v);
        return {v[2:0], v[WORD_SIZE-1:3]};
    endfunction

    function automatic logic [WORD_SIZE-1:0] rol3(input logic [WORD_SIZE-1:0] v);
        return {v[WORD_SIZE-4:0], v[WORD_SIZE-1:WORD_SIZE-3]};
    endfunction

    // Key-schedule step and shared round datapath (encrypt or inverse round).
    always_comb begin
        l_new_d = (k_q + ror8(l_q[0])) ^ WORD_SIZE'(ctr_q);
        k_d     = rol3(k_q) ^ l_new_d;
        for (int i = 0; i < KEY_WORDS - 2; i++) begin
            l_d[i] = l_q[i+1];
        end
        l_d[KEY_WORDS-2] = l_new_d;
        rd_idx_d = mode_q ? (LAST - ctr_q) : ctr_q;
        rk_d     = rk_mem[rd_idx_d];
        if (mode_q) begin
            y_d = ror3(x_q ^ y_q);
            x_d = rol8((x_q ^ rk_d) - y_d);
        end else begin
            x_d = (ror8(x_q) + y_q) ^ rk_d;
            y_d = rol3(y_q) ^ x_d;
        end
    end

    // Round-key buffer: written only while expanding, contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == ST_EXPAND)) begin
            rk_mem[ctr_q] <= k_q;
        end
    end

    // Control FSM with registered outputs and working registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ctr_q        <= '0;
            key_valid_q  <= 1'b0;
            mode_q       <= 1'b0;
            pend_key_q   <= '0;
            cached_key_q <= '0;
            k_q          <= '0;
            for (int i = 0; i < KEY_WORDS - 1; i++) begin
                l_q[i] <= '0;
            end
            x_q          <= '0;
            y_q          <= '0;
            data_out_q   <= '0;
            finished_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            finished_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (signal_start) begin
                        mode_q     <= mode;
                        pend_key_q <= key;
                        k_q        <= key[WORD_SIZE-1:0];
                        for (int i = 0; i < KEY_WORDS - 1; i++) begin
                            l_q[i] <= key[(i+1)*WORD_SIZE +: WORD_SIZE];
                        end
                        x_q    <= data_in[2*WORD_SIZE-1:WORD_SIZE];
                        y_q    <= data_in[WORD_SIZE-1:0];
                        ctr_q  <= '0;
                        busy_q <= 1'b1;
                        if (key_valid_q && (key == cached_key_q) && !key_invalidate) begin
                            state_q <= ST_ROUND;
                        end else begin
                            state_q <= ST_EXPAND;
                        end
                    end
                end
                ST_EXPAND: begin
                    k_q <= k_d;
                    l_q <= l_d;
                    if (ctr_q == LAST) begin
                        cached_key_q <= pend_key_q;
                        key_valid_q  <= 1'b1;
                        ctr_q        <= '0;
                        state_q      <= ST_ROUND;
                    end else begin
                        ctr_q <= ctr_q + CTR_W'(1);
                    end
                end
                ST_ROUND: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    if (ctr_q == LAST) begin
                        ctr_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        ctr_q <= ctr_q + CTR_W'(1);
                    end
                end
                ST_DONE: begin
                    data_out_q <= {x_q, y_q};
                    finished_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
            // Invalidate overrides everything, including a completing expansion.
            if (key_invalidate) begin
                key_valid_q <= 1'b0;
            end
        end
    end

    assign data_out       = data_out_q;
    assign finished       = finished_q;
    assign busy           = busy_q;
    assign state_response = state_q;

endmodule

// File: tb/tb_speck_iterative_core.sv
// Randomised self-checking bench for speck_iterative_core against an array-based SPECK model.
module tb_speck_iterative_core;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [127:0] key = '0;
    logic         kinv = 1'b0;
    logic [127:0] din = '0;
    logic [127:0] dout;
    logic         fin;
    logic         busy;
    logic [1:0]   st;

    logic         start64 = 1'b0;
    logic         mode64 = 1'b0;
    logic [127:0] key64 = '0;
    logic         kinv64 = 1'b0;
    logic [63:0]  din64 = '0;
    logic [63:0]  dout64;
    logic         fin64;
    logic         busy64;
    logic [1:0]   st64;

    int           n_cmp = 0;
    int           n_err = 0;
    bit           tb_valid = 1'b0;
    logic [127:0] tb_key = '0;

    speck_iterative_core dut (
        .clk(clk), .rst_n(rst_n), .signal_start(start), .mode(mode), .key(key),
        .key_invalidate(kinv), .data_in(din), .data_out(dout), .finished(fin),
        .busy(busy), .state_response(st)
    );

    speck_iterative_core #(.WORD_SIZE(32), .KEY_WORDS(4), .NR_ROUNDS(27)) dut64 (
        .clk(clk), .rst_n(rst_n), .signal_start(start64), .mode(mode64), .key(key64),
        .key_invalidate(kinv64), .data_in(din64), .data_out(dout64), .finished(fin64),
        .busy(busy64), .state_response(st64)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] m_ror(input logic [63:0] v, input int s, input int n);
        logic [63:0] mask;
        mask = (64'd1 << n) - 64'd1;
        v = v & mask;
        return ((v >> s) | (v << (n - s))) & mask;
    endfunction

    // Textbook SPECK: full key expansion into k[], then forward or reversed rounds.
    task automatic model(input logic [255:0] kin, input logic [127:0] blk, input int n,
                         input int m, input int t, input bit dec, output logic [127:0] res);
        logic [63:0] mask, x, y;
        logic [63:0] k [0:63];
        logic [63:0] l [0:71];
        mask = (64'd1 << n) - 64'd1;
        k[0] = 64'(kin) & mask;
        for (int i = 0; i < m - 1; i++) l[i] = 64'(kin >> ((i + 1) * n)) & mask;
        for (int i = 0; i < t - 1; i++) begin
            l[i+m-1] = ((k[i] + m_ror(l[i], 8, n)) & mask) ^ 64'(i);
            k[i+1]   = m_ror(k[i], n - 3, n) ^ l[i+m-1];
        end
        x = 64'(blk >> n) & mask;
        y = 64'(blk) & mask;
        if (!dec) begin
            for (int i = 0; i < t; i++) begin
                x = ((m_ror(x, 8, n) + y) & mask) ^ k[i];
                y = m_ror(y, n - 3, n) ^ x;
            end
        end else begin
            for (int i = t - 1; i >= 0; i--) begin
                y = m_ror(x ^ y, 3, n);
                x = m_ror(((x ^ k[i]) - y) & mask, n - 8, n);
            end
        end
        res = ({64'd0, x} << n) | {64'd0, y};
    endtask

    // One operation on the 128/128 core; inv_at/abort_at are edge counts after the start edge.
    task automatic run_op(input logic [127:0] k, input logic [127:0] blk, input bit md,
                          input int inv_at, input int abort_at, input bit toggle,
                          input string tag, output logic [127:0] res);
        logic [127:0] exp_res;
        int lat, fins, exp_lat;
        bit saw, hit;
        hit = tb_valid && (k == tb_key);
        exp_lat = hit ? 33 : 65;
        model({128'd0, k}, blk, 64, 2, 32, md, exp_res);
        @(negedge clk);
        key = k; din = blk; mode = md; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        saw = (st == 2'd1);
        check_eq({tag, ":busy_rise"}, {127'd0, busy}, 128'd1);
        while (lat < 200) begin
            if (lat == inv_at) kinv = 1'b1;
            if (lat == abort_at) rst_n = 1'b0;
            if (toggle) start = ~start;
            @(posedge clk); #1;
            lat++;
            kinv = 1'b0;
            if (abort_at >= 0 && lat == abort_at + 1) begin
                rst_n = 1'b1;
                break;
            end
            if (st == 2'd1) saw = 1'b1;
            if (fin) break;
        end
        start = 1'b0;
        res = dout;
        if (abort_at >= 0) begin
            check_eq({tag, ":abort_busy"}, {127'd0, busy}, 128'd0);
            check_eq({tag, ":abort_state"}, {126'd0, st}, 128'd0);
            fins = 0;
            repeat (70) begin
                @(posedge clk); #1;
                if (fin) fins++;
            end
            check_eq({tag, ":abort_no_fin"}, 128'(fins), 128'd0);
            tb_valid = 1'b0;
        end else begin
            check_eq({tag, ":fin"}, {127'd0, fin}, 128'd1);
            check_eq({tag, ":latency"}, 128'(lat), 128'(exp_lat));
            check_eq({tag, ":expand_seen"}, {127'd0, saw}, {127'd0, !hit});
            check_eq({tag, ":data"}, dout, exp_res);
            check_eq({tag, ":busy_fall"}, {127'd0, busy}, 128'd0);
            fins = 0;
            repeat (toggle ? 70 : 2) begin
                @(posedge clk); #1;
                if (fin) fins++;
            end
            check_eq({tag, ":single_fin"}, 128'(fins), 128'd0);
            tb_key = k;
            tb_valid = (inv_at < 0);
        end
    endtask

    task automatic run64(input logic [127:0] k, input logic [63:0] blk, input bit md,
                         input int exp_lat, input logic [63:0] exp, input string tag);
        int lat;
        @(negedge clk);
        key64 = k; din64 = blk; mode64 = md; start64 = 1'b1;
        @(posedge clk); #1;
        start64 = 1'b0;
        lat = 0;
        while (!fin64 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, ":fin"}, {127'd0, fin64}, 128'd1);
        check_eq({tag, ":latency"}, 128'(lat), 128'(exp_lat));
        check_eq({tag, ":data"}, {64'd0, dout64}, {64'd0, exp});
    endtask

    initial begin
        logic [127:0] r, ka, kb, kr, blk;
        logic [127:0] m64;
        logic [63:0]  b64;
        int           inv;
        ka = 128'h0f0e0d0c0b0a0908_0706050403020100;

        rst_n = 1'b0;
        start = 1'b1;
        start64 = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("reset:data_out", dout, 128'd0);
            check_eq("reset:finished", {127'd0, fin}, 128'd0);
            check_eq("reset:busy", {127'd0, busy}, 128'd0);
            check_eq("reset:state", {126'd0, st}, 128'd0);
        end
        @(negedge clk);
        start = 1'b0;
        start64 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("reset:idle_after", {127'd0, busy}, 128'd0);

        run_op(ka, 128'h6c61766975716520_7469206564616d20, 1'b0, -1, -1, 1'b0, "kat_enc_cold", r);
        check_eq("kat_enc_cold:vector", r, 128'ha65d985179783265_7860fedf5c570d18);
        run_op(ka, 128'ha65d985179783265_7860fedf5c570d18, 1'b1, -1, -1, 1'b0, "kat_dec_warm", r);
        check_eq("kat_dec_warm:vector", r, 128'h6c61766975716520_7469206564616d20);

        kb = {$urandom, $urandom, $urandom, $urandom};
        blk = {$urandom, $urandom, $urandom, $urandom};
        run_op(kb, blk, 1'b0, -1, -1, 1'b0, "key_change", r);
        run_op(kb, blk, 1'b1, 10, -1, 1'b0, "inval_mid_round", r);
        run_op(kb, blk, 1'b0, -1, -1, 1'b0, "after_inval", r);
        run_op(kb, ~blk, 1'b1, -1, -1, 1'b1, "start_toggle", r);
        run_op(kb, blk, 1'b0, -1, 10, 1'b0, "reset_abort", r);
        run_op(kb, blk, 1'b0, -1, -1, 1'b0, "after_abort", r);

        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                kr = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                kr = tb_key;
            end
            blk = {$urandom, $urandom, $urandom, $urandom};
            inv = -1;
            if ($urandom_range(0, 3) == 0) begin
                inv = (tb_valid && kr == tb_key) ? int'($urandom_range(1, 31))
                                                 : int'($urandom_range(33, 63));
            end
            run_op(kr, blk, 1'($urandom_range(0, 1)), inv, -1, 1'b0, $sformatf("rand%0d", i), r);
        end

        run64(128'h1b1a1918_13121110_0b0a0908_03020100, 64'h3b726574_7475432d, 1'b0, 55,
              64'h8c6fa548_454e028b, "s64_enc_cold");
        run64(128'h1b1a1918_13121110_0b0a0908_03020100, 64'h8c6fa548_454e028b, 1'b1, 28,
              64'h3b726574_7475432d, "s64_dec_warm");
        kr = {$urandom, $urandom, $urandom, $urandom};
        b64 = {$urandom, $urandom};
        model({128'd0, kr}, {64'd0, b64}, 32, 4, 27, 1'b0, m64);
        run64(kr, b64, 1'b0, 55, m64[63:0], "s64_rand_enc");
        run64(kr, m64[63:0], 1'b1, 28, b64, "s64_rand_dec");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
